// File: rtl/softplus_exp_stream_ctrl.sv
// Ready/valid wrapper around the fixed-latency FP16 softplus/exp engine: credit-gated issue,
// exp/softplus realignment and an in-order FWFT result FIFO. Optional counters: SPX_PERF_CNT_EN.
module softplus_exp_stream_ctrl #(
   parameter int DW         = 16,
   parameter int EXP_LAT    = 13,
   parameter int SP_LAT     = 16,
   parameter int FIFO_DEPTH = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic          s_mode,
   input  logic [DW-1:0] s_data,
   output logic          eng_valid_o,
   output logic          eng_mode_o,
   output logic [DW-1:0] eng_x_o,
   input  logic [DW-1:0] eng_y_s_i,
   input  logic          eng_valid_s_i,
   input  logic [DW-1:0] eng_y_e_i,
   input  logic          eng_valid_e_i,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_mode,
   output logic          busy_o,
   output logic          err_o,
   output logic [31:0]   perf_issue_o,
   output logic [31:0]   perf_stall_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int AL = SP_LAT - EXP_LAT;
   localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);

   logic          accept;
   logic [CW-1:0] credits_reg, credits_next;
   logic [CW+1:0] cred_sum;

   assign accept = s_valid & s_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         eng_valid_o <= 1'b0;
         eng_mode_o  <= 1'b0;
         eng_x_o     <= '0;
      end else begin
         eng_valid_o <= accept;
         if (accept) begin
            eng_mode_o <= s_mode;
            eng_x_o    <= s_data;
         end
      end
   end

   // Tracker stage k holds the op issued k+1 cycles ago.
   logic [SP_LAT-1:0] trk_v_reg, trk_m_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         trk_v_reg <= '0;
         trk_m_reg <= '0;
      end else begin
         trk_v_reg[0] <= eng_valid_o;
         trk_m_reg[0] <= eng_mode_o;
         for (int i = 1; i < SP_LAT; i++) begin
            trk_v_reg[i] <= trk_v_reg[i-1];
            trk_m_reg[i] <= trk_m_reg[i-1];
         end
      end
   end

   logic exp_e, exp_s, good_e, good_s, miss_e, miss_s, mism_e, mism_s;

   assign exp_e  = trk_v_reg[EXP_LAT-1] & ~trk_m_reg[EXP_LAT-1];
   assign exp_s  = trk_v_reg[SP_LAT-1]  &  trk_m_reg[SP_LAT-1];
   assign good_e = eng_valid_e_i & exp_e;
   assign good_s = eng_valid_s_i & exp_s;
   assign miss_e = exp_e & ~eng_valid_e_i;
   assign miss_s = exp_s & ~eng_valid_s_i;
   assign mism_e = eng_valid_e_i ^ exp_e;
   assign mism_s = eng_valid_s_i ^ exp_s;

   logic          al_v;
   logic [DW-1:0] al_y;

   generate
      if (AL == 0) begin : g_no_align
         assign al_v = good_e;
         assign al_y = eng_y_e_i;
      end else begin : g_align
         logic [AL-1:0] v_reg;
         logic [DW-1:0] y_reg [AL];

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               v_reg <= '0;
               for (int i = 0; i < AL; i++) y_reg[i] <= '0;
            end else begin
               v_reg[0] <= good_e;
               y_reg[0] <= eng_y_e_i;
               for (int i = 1; i < AL; i++) begin
                  v_reg[i] <= v_reg[i-1];
                  y_reg[i] <= y_reg[i-1];
               end
            end
         end

         assign al_v = v_reg[AL-1];
         assign al_y = y_reg[AL-1];
      end
   endgenerate

   logic          push, collide, push_mode;
   logic [DW-1:0] push_data;

   assign collide   = al_v & good_s;
   assign push      = al_v | good_s;
   assign push_mode = good_s;
   assign push_data = good_s ? eng_y_s_i : al_y;

   // Result FIFO, first-word-fall-through; pointers carry one wrap bit.
   logic [AW:0] wr_ptr_reg, rd_ptr_reg;
   logic [DW:0] mem [FIFO_DEPTH];
   logic [DW:0] head;
   logic        empty, full, pop, push_ok, overflow;

   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign head     = mem[rd_ptr_reg[AW-1:0]];
   assign m_valid  = ~empty;
   assign m_data   = empty ? '0 : head[DW-1:0];
   assign m_mode   = ~empty & head[DW];
   assign pop      = m_valid & m_ready;
   assign push_ok  = push & (~full | pop);
   assign overflow = push & full & ~pop;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= {push_mode, push_data};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Missing results and collisions give their slot back so credits never leak.
   always_comb begin
      cred_sum = {2'b00, credits_reg} + (CW+2)'(pop) + (CW+2)'(miss_e)
               + (CW+2)'(miss_s) + (CW+2)'(collide) - (CW+2)'(accept);
      credits_next = (cred_sum > (CW+2)'(FIFO_DEPTH)) ? CRED_MAX : cred_sum[CW-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         credits_reg <= CRED_MAX;
         s_ready     <= 1'b0;
         busy_o      <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         credits_reg <= credits_next;
         s_ready     <= (credits_next != '0);
         busy_o      <= (credits_next != CRED_MAX);
         err_o       <= err_o | mism_e | mism_s | collide | overflow;
      end
   end

`ifdef SPX_PERF_CNT_EN
   logic [31:0] perf_issue_reg, perf_stall_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_issue_reg <= '0;
         perf_stall_reg <= '0;
      end else begin
         if (eng_valid_o && perf_issue_reg != 32'hFFFF_FFFF)
            perf_issue_reg <= perf_issue_reg + 32'd1;
         if (s_valid && !s_ready && perf_stall_reg != 32'hFFFF_FFFF)
            perf_stall_reg <= perf_stall_reg + 32'd1;
      end
   end

   assign perf_issue_o = perf_issue_reg;
   assign perf_stall_o = perf_stall_reg;
`else
   assign perf_issue_o = '0;
   assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_softplus_exp_stream_ctrl.sv
// Scoreboard bench for softplus_exp_stream_ctrl: fixed-latency engine model, expected results
// queued at acceptance and compared by a monitor when the DUT presents them.
module tb_softplus_exp_stream_ctrl;
   localparam int DW = 16, EXP_LAT = 13, SP_LAT = 16, FIFO_DEPTH = 32;
   localparam int E2E = 1 + SP_LAT + 1;

   logic clk = 1'b0, rstn = 1'b0;
   logic s_valid = 1'b0, s_ready, s_mode = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic eng_valid_o, eng_mode_o;
   logic [DW-1:0] eng_x_o, eng_y_s_i, eng_y_e_i;
   logic eng_valid_s_i, eng_valid_e_i;
   logic m_valid, m_ready = 1'b1, m_mode;
   logic [DW-1:0] m_data;
   logic busy_o, err_o;
   logic [31:0] perf_issue_o, perf_stall_o;
   logic inj_e = 1'b0;

   softplus_exp_stream_ctrl #(.DW(DW), .EXP_LAT(EXP_LAT), .SP_LAT(SP_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode), .s_data(s_data),
      .eng_valid_o(eng_valid_o), .eng_mode_o(eng_mode_o), .eng_x_o(eng_x_o),
      .eng_y_s_i(eng_y_s_i), .eng_valid_s_i(eng_valid_s_i), .eng_y_e_i(eng_y_e_i), .eng_valid_e_i(eng_valid_e_i),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_mode(m_mode),
      .busy_o(busy_o), .err_o(err_o), .perf_issue_o(perf_issue_o), .perf_stall_o(perf_stall_o));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0, n_errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Engine transfer functions (known points from the engine's characterisation).
   function automatic logic [15:0] f_exp(input logic [15:0] x);
      case (x)
         16'h3C00: return 16'h4170;
         16'h0000: return 16'h3C00;
         default:  return {x[7:0], x[15:8]} ^ 16'h1234;
      endcase
   endfunction

   function automatic logic [15:0] f_sp(input logic [15:0] x);
      if (x == 16'h0000) return 16'h398C;
      return x + 16'h0F0F;
   endfunction

   function automatic logic [15:0] model(input logic m, input logic [15:0] x);
      return m ? f_sp(x) : f_exp(x);
   endfunction

   // Engine: results for an op issued in cycle t appear in cycle t+EXP_LAT / t+SP_LAT.
   typedef struct packed { logic v; logic m; logic [15:0] x; } op_t;
   op_t eng_pipe [SP_LAT];
   op_t pe, ps;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < SP_LAT; i++) eng_pipe[i] <= '0;
      end else begin
         eng_pipe[0] <= {eng_valid_o, eng_mode_o, eng_x_o};
         for (int i = 1; i < SP_LAT; i++) eng_pipe[i] <= eng_pipe[i-1];
      end
   end

   assign pe            = eng_pipe[EXP_LAT-1];
   assign ps            = eng_pipe[SP_LAT-1];
   assign eng_valid_e_i = (pe.v & ~pe.m) | inj_e;
   assign eng_y_e_i     = (pe.v & ~pe.m) ? f_exp(pe.x) : 16'hDEAD;
   assign eng_valid_s_i = ps.v & ps.m;
   assign eng_y_s_i     = (ps.v & ps.m) ? f_sp(ps.x) : 16'hBEEF;

   // Scoreboard
   typedef struct { logic m; logic [15:0] d; int c; } rec_t;
   rec_t sb_q[$], iss_q[$];
   int   out_cyc_q[$];
   rec_t mon_r, acc_r;
   int   n_acc = 0, n_issue = 0, n_stall = 0, n_out = 0;
   bit   lat_chk = 1'b0;

   always @(negedge clk) begin
      if (!rstn) begin
         n_issue <= 0;
         n_stall <= 0;
      end else begin
         if (eng_valid_o) begin
            n_issue <= n_issue + 1;
            if (iss_q.size() == 0) check("issue_unexpected", 32'd1, 32'd0);
            else begin
               mon_r = iss_q.pop_front();
               check("issue_x", {16'h0, eng_x_o}, {16'h0, mon_r.d});
               check("issue_mode", {31'h0, eng_mode_o}, {31'h0, mon_r.m});
               check("issue_latency", cyc - mon_r.c, 32'd1);
            end
         end
         if (m_valid && m_ready) begin
            out_cyc_q.push_back(cyc);
            n_out <= n_out + 1;
            $display("out cycle %0d: mode=%0d data=0x%04h", cyc, m_mode, m_data);
            if (sb_q.size() == 0) check("out_unexpected", 32'd1, 32'd0);
            else begin
               mon_r = sb_q.pop_front();
               check("out_data", {16'h0, m_data}, {16'h0, mon_r.d});
               check("out_mode", {31'h0, m_mode}, {31'h0, mon_r.m});
               if (lat_chk) check("out_latency", cyc - mon_r.c, E2E);
            end
         end
         if (s_valid && s_ready) begin
            n_acc <= n_acc + 1;
            acc_r.m = s_mode;
            acc_r.d = model(s_mode, s_data);
            acc_r.c = cyc;
            sb_q.push_back(acc_r);
            acc_r.d = s_data;
            iss_q.push_back(acc_r);
         end
         if (s_valid && !s_ready) n_stall <= n_stall + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic m, input logic [15:0] x);
      int t = 0;
      s_valid = 1'b1;
      s_mode  = m;
      s_data  = x;
      forever begin
         @(negedge clk);
         if (s_ready) break;
         t++;
         if (t > 2000) begin
            check("send_timeout", 32'd1, 32'd0);
            break;
         end
      end
      step();
      s_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int t = 0;
      while ((sb_q.size() != 0 || busy_o) && t < budget) begin
         step();
         t++;
      end
      check("drain_in_time", {31'h0, t < budget}, 32'd1);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_s_ready"}, {31'h0, s_ready}, 32'd0);
      check({tag, "_eng_valid"}, {31'h0, eng_valid_o}, 32'd0);
      check({tag, "_eng_mode"}, {31'h0, eng_mode_o}, 32'd0);
      check({tag, "_eng_x"}, {16'h0, eng_x_o}, 32'd0);
      check({tag, "_m_valid"}, {31'h0, m_valid}, 32'd0);
      check({tag, "_m_data"}, {16'h0, m_data}, 32'd0);
      check({tag, "_m_mode"}, {31'h0, m_mode}, 32'd0);
      check({tag, "_busy"}, {31'h0, busy_o}, 32'd0);
      check({tag, "_err"}, {31'h0, err_o}, 32'd0);
      check({tag, "_perf_issue"}, perf_issue_o, 32'd0);
      check({tag, "_perf_stall"}, perf_stall_o, 32'd0);
   endtask

   task automatic perf_checks(input string tag);
`ifdef SPX_PERF_CNT_EN
      check({tag, "_perf_issue"}, perf_issue_o, n_issue);
      check({tag, "_perf_stall"}, perf_stall_o, n_stall);
`else
      check({tag, "_perf_issue"}, perf_issue_o, 32'd0);
      check({tag, "_perf_stall"}, perf_stall_o, 32'd0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bit rand_done;
      #1;
      reset_checks("reset");
      repeat (3) step();
      rstn = 1'b1;
      check("s_ready_before_first_clk", {31'h0, s_ready}, 32'd0);
      step();
      check("s_ready_after_release", {31'h0, s_ready}, 32'd1);
      check("busy_idle", {31'h0, busy_o}, 32'd0);

      // Single exp with end-to-end latency check
      lat_chk = 1'b1;
      send(1'b0, 16'h3C00);
      check("busy_in_flight", {31'h0, busy_o}, 32'd1);
      drain(200);
      check("single_err", {31'h0, err_o}, 32'd0);

      // Softplus then exp back to back: one result per cycle, no collision
      out_cyc_q.delete();
      send(1'b1, 16'h0000);
      send(1'b0, 16'h0000);
      drain(200);
      lat_chk = 1'b0;
      check("b2b_count", out_cyc_q.size(), 32'd2);
      if (out_cyc_q.size() == 2) check("b2b_spacing", out_cyc_q[1] - out_cyc_q[0], 32'd1);
      check("b2b_err", {31'h0, err_o}, 32'd0);

      // Backpressure: 40 requests against a stalled sink
      m_ready = 1'b0;
      base = n_acc;
      fork
         begin
            for (int i = 0; i < 40; i++) send(i[0], 16'(i * 37 + 5));
         end
         begin
            repeat (60) step();
            check("bp_accepted", n_acc - base, 32'd32);
            check("bp_s_ready", {31'h0, s_ready}, 32'd0);
            check("bp_m_valid", {31'h0, m_valid}, 32'd1);
            check("bp_busy", {31'h0, busy_o}, 32'd1);
            perf_checks("bp");
            m_ready = 1'b1;
         end
      join
      drain(2000);
      check("bp_total_accepted", n_acc - base, 32'd40);
      check("bp_s_ready_after", {31'h0, s_ready}, 32'd1);
      check("bp_busy_after", {31'h0, busy_o}, 32'd0);
      check("bp_err", {31'h0, err_o}, 32'd0);

      // Random traffic with a randomly stalling sink
      rand_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               repeat ($urandom_range(0, 2)) step();
               send(1'($urandom_range(0, 1)), 16'($urandom));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               step();
               m_ready = ($urandom_range(0, 3) != 0);
            end
            m_ready = 1'b1;
         end
      join
      drain(2000);
      check("rand_err", {31'h0, err_o}, 32'd0);
      perf_checks("rand");

      // Spurious exp result with nothing in flight
      repeat (5) step();
      inj_e = 1'b1;
      step();
      inj_e = 1'b0;
      check("spur_err", {31'h0, err_o}, 32'd1);
      check("spur_m_valid", {31'h0, m_valid}, 32'd0);
      check("spur_busy", {31'h0, busy_o}, 32'd0);
      check("spur_s_ready", {31'h0, s_ready}, 32'd1);
      repeat (5) step();
      check("spur_err_sticky", {31'h0, err_o}, 32'd1);
      check("spur_m_valid_later", {31'h0, m_valid}, 32'd0);

      // Reset with ops queued and in flight
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(1'b1, 16'(16'h1000 + i));
      repeat (20) step();
      for (int i = 0; i < 10; i++) send(i[0], 16'(16'h2000 + i));
      rstn = 1'b0;
      #1;
      reset_checks("midreset");
      sb_q.delete();
      iss_q.delete();
      repeat (3) step();
      rstn = 1'b1;
      m_ready = 1'b1;
      step();
      check("post_reset_s_ready", {31'h0, s_ready}, 32'd1);
      base = n_out;
      lat_chk = 1'b1;
      send(1'b0, 16'h3C00);
      drain(200);
      lat_chk = 1'b0;
      repeat (30) step();
      check("post_reset_outputs", n_out - base, 32'd1);
      check("post_reset_m_valid", {31'h0, m_valid}, 32'd0);
      check("post_reset_err", {31'h0, err_o}, 32'd0);
      check("post_reset_busy", {31'h0, busy_o}, 32'd0);
      perf_checks("final");
      check("scoreboard_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/softplus_exp_stream_ctrl.md
Name: softplus_exp_stream_ctrl

Overview:
- Stream front/back end for the shared FP16 softplus/exp engine, which has no backpressure and a fixed latency.
- Accepts ready/valid requests of {mode, x} and issues them to the engine only when result storage is guaranteed (credit scheme).
- Re-aligns the early exp results behind the later softplus results and buffers the merged results in a FIFO.
- Presents results downstream in issue order over ready/valid.

Parameters:
- DW, 16, data width (FP16).
- EXP_LAT, 13, cycles from engine valid_i to valid_o_e.
- SP_LAT, 16, cycles from engine valid_i to valid_o_S; must be >= EXP_LAT.
- FIFO_DEPTH, 32, result FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- s_valid  in  1  request valid.
- s_ready  out  1  request accepted when s_valid & s_ready.
- s_mode  in  1  1 = softplus, 0 = exp.
- s_data  in  DW  FP16 operand x.
- eng_valid_o  out  1  issue strobe to engine valid_i.
- eng_mode_o  out  1  to engine mode_softplus_i.
- eng_x_o  out  DW  to engine x_i.
- eng_y_s_i  in  DW  engine softplus result.
- eng_valid_s_i  in  1  engine softplus valid.
- eng_y_e_i  in  DW  engine exp result.
- eng_valid_e_i  in  1  engine exp valid.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed when m_valid & m_ready.
- m_data  out  DW  FP16 result.
- m_mode  out  1  mode of that result.
- busy_o  out  1  any request in flight or FIFO non-empty.
- err_o  out  1  sticky protocol error.
- perf_issue_o  out  32  issued-op count (optional feature).
- perf_stall_o  out  32  stall-cycle count (optional feature).

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk.
- Reset values: s_ready=0, eng_valid_o=0, eng_mode_o=0, eng_x_o=0, m_valid=0, m_data=0, m_mode=0, busy_o=0, err_o=0, perf counters=0, credits=FIFO_DEPTH.
- s_ready is asserted from the first clock after reset release.
- Credits:
  - Counter range 0..FIFO_DEPTH; credits = FIFO_DEPTH - (in-flight + FIFO occupancy).
  - Decremented on issue, incremented on FIFO pop; simultaneous issue and pop leaves it unchanged.
  - s_ready = (credits != 0), registered (computed from next-state credits).
- Issue path: on accept, eng_valid_o/eng_mode_o/eng_x_o are registered 1 cycle later, one op per cycle max. eng_valid_o is 0 on all other cycles; eng_x_o/eng_mode_o hold their last value.
- Expectation tracker: SP_LAT-deep shift register of {valid, mode} fed at issue time; taps at EXP_LAT and SP_LAT give the expected arrivals.
  - eng_valid_e_i must equal (tap_EXP.valid & ~tap_EXP.mode).
  - eng_valid_s_i must equal (tap_SP.valid & tap_SP.mode).
  - Any mismatch sets err_o (sticky until reset). The unexpected result is discarded; an expected-but-missing slot pushes nothing but still returns its credit.
- Alignment: exp results {y, valid} pass through a (SP_LAT-EXP_LAT)-deep shift register. Merged push = aligned_exp_valid | eng_valid_s_i, data from whichever is valid.
- Collision: both valid in the same cycle is impossible under correct tracking. If it occurs: set err_o, push the softplus result, drop the exp result, and return one extra credit.
- End-to-end latency: request acceptance to m_valid = 1 + SP_LAT + 1 cycles when the FIFO is empty (for both modes). Order is strictly issue order.
- FIFO: first-word-fall-through; m_valid = !empty; m_data/m_mode = head entry. Push and pop in the same cycle are allowed, including at full and empty. Pointer wrap at FIFO_DEPTH.
- Push while full: cannot occur (credits); if it does, set err_o and drop the push.
- busy_o = (credits != FIFO_DEPTH), registered.
- Reset mid-operation: all state, in-flight tracking and FIFO contents are cleared. The engine shares rstn.

Optional Feature:
- Macro: SPX_PERF_CNT_EN.
- Defined: perf_issue_o counts issues; perf_stall_o counts cycles with s_valid & ~s_ready. Both are 32-bit and saturate at 0xFFFFFFFF.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Single exp, x=0x3C00 (1.0), engine model returns 0x4170 -> m_valid 18 cycles after accept with m_data=0x4170, m_mode=0; err_o=0.
- Back-to-back stream, every cycle: softplus x=0x0000, then exp x=0x0000 -> the exp result (0x3C00) lands in the same aligned cycle as the following slot. Outputs must be 0x398C (mode 1) then 0x3C00 (mode 0), in order, one per cycle, no collision, err_o=0.
- m_ready=0, 40 continuous requests (FIFO_DEPTH=32) -> exactly 32 accepted, s_ready=0 thereafter, perf_stall_o = stall cycles. Raise m_ready -> 32 results in order, then remaining 8 accepted; credits return to 32, busy_o falls.
- Full FIFO with simultaneous push and pop at steady state -> occupancy constant, no drop, err_o=0.
- Inject a spurious eng_valid_e_i with no op in flight -> err_o=1 and stays 1, nothing pushed, credits unchanged.
- Assert rstn low with 10 ops in flight and 5 queued -> all outputs at reset values immediately. After release, a new exp request completes normally with no stale data.
